// File: rtl/mips32_core.sv
// Five-stage in-order MIPS-style core (IF, ID, EX, MEM, WB) with internal memories.
// Define MIPS32_WB_BYPASS_EN to make the ID register read see the same-cycle WB write.
module mips32_core (
  input  logic clk_x,
  input  logic rst_x,
  output logic halt_x
);

  localparam logic [5:0] OpAdd  = 6'h00;
  localparam logic [5:0] OpSub  = 6'h01;
  localparam logic [5:0] OpAnd  = 6'h02;
  localparam logic [5:0] OpOr   = 6'h03;
  localparam logic [5:0] OpSlt  = 6'h04;
  localparam logic [5:0] OpMul  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h10;
  localparam logic [5:0] OpSubi = 6'h11;
  localparam logic [5:0] OpMuli = 6'h12;
  localparam logic [5:0] OpSlti = 6'h13;
  localparam logic [5:0] OpLw   = 6'h30;
  localparam logic [5:0] OpSw   = 6'h31;
  localparam logic [5:0] OpBeqz = 6'h38;
  localparam logic [5:0] OpBnez = 6'h39;
  localparam logic [5:0] OpHlt  = 6'h3f;

  localparam logic [31:0] Nop = 32'h0000_0000;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [31:0] if_id_ir_q, if_id_ir_d;
  logic [9:0]  if_id_npc_q, if_id_npc_d;
  logic [31:0] id_ex_ir_q, id_ex_ir_d;
  logic [9:0]  id_ex_npc_q, id_ex_npc_d;
  logic [31:0] id_ex_a_q, id_ex_a_d;
  logic [31:0] id_ex_b_q, id_ex_b_d;
  logic [31:0] id_ex_c_q, id_ex_c_d;
  logic [31:0] id_ex_imm_q, id_ex_imm_d;
  logic [31:0] ex_mem_ir_q, ex_mem_ir_d;
  logic [31:0] ex_mem_alu_q, ex_mem_alu_d;
  logic [31:0] ex_mem_sd_q, ex_mem_sd_d;
  logic [31:0] mem_wb_ir_q, mem_wb_ir_d;
  logic [31:0] mem_wb_alu_q, mem_wb_alu_d;
  logic [31:0] mem_wb_lmd_q, mem_wb_lmd_d;

  logic [31:0] rd_a, rd_b, rd_c;
  logic [4:0]  id_fa, id_fb, id_fc;
  logic        hlt_in_id;
  logic [5:0]  ex_op;
  logic [31:0] ex_alu;
  logic        ex_taken;
  logic [9:0]  ex_target;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  function automatic logic writes_reg(logic [5:0] op);
    return (op <= OpMul) || ((op >= OpAddi) && (op <= OpSlti)) || (op == OpLw);
  endfunction

  // Storage lives in named blocks so it is reachable as i_f.mem, max.data and id.reg_b.
  if (1'b1) begin : i_f
    logic [31:0] mem [0:1023] = '{default: '0};
  end

  if (1'b1) begin : max
    logic [31:0] data [0:1023];
    always_ff @(posedge clk_x) begin
      if (dm_we) data[dm_addr] <= dm_wdata;
    end
  end

  if (1'b1) begin : id
    logic [31:0] reg_b [0:31];
    always_ff @(posedge clk_x) begin
      if (rf_we) reg_b[rf_waddr] <= rf_wdata;
    end
  end

  // ID: combinational register read, R0 hard-wired to zero.
  assign id_fa     = if_id_ir_q[25:21];
  assign id_fb     = if_id_ir_q[20:16];
  assign id_fc     = if_id_ir_q[15:11];
  assign hlt_in_id = (if_id_ir_q[31:26] == OpHlt);

  always_comb begin
    rd_a = (id_fa == 5'd0) ? 32'd0 : id.reg_b[id_fa];
    rd_b = (id_fb == 5'd0) ? 32'd0 : id.reg_b[id_fb];
    rd_c = (id_fc == 5'd0) ? 32'd0 : id.reg_b[id_fc];
`ifdef MIPS32_WB_BYPASS_EN
    if (rf_we && (rf_waddr == id_fa)) rd_a = rf_wdata;
    if (rf_we && (rf_waddr == id_fb)) rd_b = rf_wdata;
    if (rf_we && (rf_waddr == id_fc)) rd_c = rf_wdata;
`endif
  end

  // EX
  assign ex_op     = id_ex_ir_q[31:26];
  assign ex_taken  = ((ex_op == OpBeqz) && (id_ex_a_q == 32'd0)) ||
                     ((ex_op == OpBnez) && (id_ex_a_q != 32'd0));
  assign ex_target = id_ex_npc_q + id_ex_imm_q[9:0];

  always_comb begin
    ex_alu = 32'd0;
    case (ex_op)
      OpAdd:        ex_alu = id_ex_b_q + id_ex_c_q;
      OpSub:        ex_alu = id_ex_b_q - id_ex_c_q;
      OpAnd:        ex_alu = id_ex_b_q & id_ex_c_q;
      OpOr:         ex_alu = id_ex_b_q | id_ex_c_q;
      OpSlt:        ex_alu = {31'd0, ($signed(id_ex_b_q) < $signed(id_ex_c_q))};
      OpMul:        ex_alu = id_ex_b_q * id_ex_c_q;
      OpAddi, OpLw,
      OpSw:         ex_alu = id_ex_b_q + id_ex_imm_q;
      OpSubi:       ex_alu = id_ex_b_q - id_ex_imm_q;
      OpMuli:       ex_alu = id_ex_b_q * id_ex_imm_q;
      OpSlti:       ex_alu = {31'd0, ($signed(id_ex_b_q) < $signed(id_ex_imm_q))};
      default:      ex_alu = 32'd0;
    endcase
  end

  // MEM: reset suppresses a store in flight.
  assign dm_addr  = ex_mem_alu_q[9:0];
  assign dm_wdata = ex_mem_sd_q;
  assign dm_we    = (ex_mem_ir_q[31:26] == OpSw) && !rst_x;

  // WB: reset suppresses the register write in flight.
  assign rf_waddr = mem_wb_ir_q[25:21];
  assign rf_wdata = (mem_wb_ir_q[31:26] == OpLw) ? mem_wb_lmd_q : mem_wb_alu_q;
  assign rf_we    = writes_reg(mem_wb_ir_q[31:26]) && (rf_waddr != 5'd0) && !rst_x;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q + 10'd1;
    if_id_ir_d  = i_f.mem[pc_q];
    if_id_npc_d = pc_q + 10'd1;
    // A taken branch outranks HLT in ID, since the HLT is one of the squashed instructions.
    if (ex_taken) begin
      pc_d       = ex_target;
      if_id_ir_d = Nop;
    end else if (hlt_in_id || (state_q == StHalt)) begin
      pc_d       = pc_q;
      if_id_ir_d = Nop;
      if (hlt_in_id) state_d = StHalt;
    end

    id_ex_ir_d   = ex_taken ? Nop : if_id_ir_q;
    id_ex_npc_d  = if_id_npc_q;
    id_ex_a_d    = rd_a;
    id_ex_b_d    = rd_b;
    id_ex_c_d    = rd_c;
    id_ex_imm_d  = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};

    ex_mem_ir_d  = id_ex_ir_q;
    ex_mem_alu_d = ex_alu;
    ex_mem_sd_d  = id_ex_a_q;

    mem_wb_ir_d  = ex_mem_ir_q;
    mem_wb_alu_d = ex_mem_alu_q;
    mem_wb_lmd_d = max.data[dm_addr];
  end

  always_ff @(posedge clk_x) begin
    if (rst_x) begin
      state_q      <= StRun;
      pc_q         <= 10'd0;
      if_id_ir_q   <= Nop;
      if_id_npc_q  <= 10'd0;
      id_ex_ir_q   <= Nop;
      id_ex_npc_q  <= 10'd0;
      id_ex_a_q    <= 32'd0;
      id_ex_b_q    <= 32'd0;
      id_ex_c_q    <= 32'd0;
      id_ex_imm_q  <= 32'd0;
      ex_mem_ir_q  <= Nop;
      ex_mem_alu_q <= 32'd0;
      ex_mem_sd_q  <= 32'd0;
      mem_wb_ir_q  <= Nop;
      mem_wb_alu_q <= 32'd0;
      mem_wb_lmd_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_id_ir_q   <= if_id_ir_d;
      if_id_npc_q  <= if_id_npc_d;
      id_ex_ir_q   <= id_ex_ir_d;
      id_ex_npc_q  <= id_ex_npc_d;
      id_ex_a_q    <= id_ex_a_d;
      id_ex_b_q    <= id_ex_b_d;
      id_ex_c_q    <= id_ex_c_d;
      id_ex_imm_q  <= id_ex_imm_d;
      ex_mem_ir_q  <= ex_mem_ir_d;
      ex_mem_alu_q <= ex_mem_alu_d;
      ex_mem_sd_q  <= ex_mem_sd_d;
      mem_wb_ir_q  <= mem_wb_ir_d;
      mem_wb_alu_q <= mem_wb_alu_d;
      mem_wb_lmd_q <= mem_wb_lmd_d;
    end
  end

  assign halt_x = (state_q == StHalt);

endmodule

// File: tb/tb_mips32_core.sv
// Bench for mips32_core: preloads programs hierarchically and scoreboards final register and
// data-memory contents plus halt/PC behaviour.
module tb_mips32_core;

  logic clk_x;
  logic rst_x;
  logic halt_x;

  mips32_core dut (
    .clk_x  (clk_x),
    .rst_x  (rst_x),
    .halt_x (halt_x)
  );

  initial clk_x = 1'b0;
  always #5 clk_x = ~clk_x;

  typedef struct {
    string       name;
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  int          n_pass  = 0;
  int          n_total = 0;

  localparam logic [5:0] OpAdd  = 6'h00;
  localparam logic [5:0] OpSub  = 6'h01;
  localparam logic [5:0] OpAnd  = 6'h02;
  localparam logic [5:0] OpSlt  = 6'h04;
  localparam logic [5:0] OpMul  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h10;
  localparam logic [5:0] OpMuli = 6'h12;
  localparam logic [5:0] OpSlti = 6'h13;
  localparam logic [5:0] OpLw   = 6'h30;
  localparam logic [5:0] OpSw   = 6'h31;
  localparam logic [5:0] OpBeqz = 6'h38;
  localparam logic [5:0] OpBnez = 6'h39;
  localparam logic [31:0] Hlt   = 32'hFC00_0000;

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] a, logic [4:0] b,
                                        logic [4:0] c);
    return {op, a, b, c, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] a, logic [4:0] b,
                                        logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic exp_t mk(string name, bit is_mem, int idx, logic [31:0] val);
    exp_t x;
    x.name = name; x.is_mem = is_mem; x.idx = idx; x.val = val;
    return x;
  endfunction

  task automatic run(int n);
    repeat (n) @(posedge clk_x);
    #1;
  endtask

  // Holds reset and wipes all storage; the program is loaded before go().
  task automatic prep();
    rst_x = 1'b1;
    run(1);
    for (int i = 0; i < 1024; i++) begin
      dut.i_f.mem[i]  = 32'd0;
      dut.max.data[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) dut.id.reg_b[i] = 32'd0;
  endtask

  // One more reset edge, then cycle 0 (fetch of mem[0]) begins.
  task automatic go();
    run(1);
    rst_x = 1'b0;
  endtask

  task automatic test_reset();
    rst_x = 1'b1;
    run(2);
    n_total++;
    if (dut.pc_q !== 10'd0) $display("FAIL reset_pc: got %0d expected 0", dut.pc_q);
    else n_pass++;
    n_total++;
    if (halt_x !== 1'b0) $display("FAIL reset_halt: got %b expected 0", halt_x);
    else n_pass++;
    n_total++;
    if (dut.id_ex_ir_q !== 32'd0) $display("FAIL reset_ir: got %h expected 0", dut.id_ex_ir_q);
    else n_pass++;
  endtask

  task automatic test_basic();
    prep();
    dut.max.data[1] = 32'd5;
    dut.max.data[2] = 32'd7;
    dut.i_f.mem[1]  = 32'hC020_0001;
    dut.i_f.mem[2]  = 32'hC040_0002;
    dut.i_f.mem[7]  = 32'h0061_1000;
    dut.i_f.mem[12] = 32'h4883_0002;
    dut.i_f.mem[17] = 32'hC480_0003;
    sb.push_back(mk("basic_r1", 0, 1, 32'd5));
    sb.push_back(mk("basic_r2", 0, 2, 32'd7));
    sb.push_back(mk("basic_r3", 0, 3, 32'h0C));
    sb.push_back(mk("basic_r4", 0, 4, 32'h18));
    sb.push_back(mk("basic_d3", 1, 3, 32'h18));
    go();
    run(25);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.is_mem ? dut.max.data[e.idx] : dut.id.reg_b[e.idx];
      n_total++;
      if (act !== e.val) $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_r0();
    prep();
    dut.id.reg_b[3] = 32'h8000_0001;
    dut.i_f.mem[0]  = enc_i(OpMuli, 5'd4, 5'd3, 16'd2);
    dut.i_f.mem[1]  = enc_i(OpAddi, 5'd0, 5'd0, 16'd5);
    dut.i_f.mem[2]  = enc_i(OpAddi, 5'd5, 5'd0, 16'hFFFF);
    dut.i_f.mem[6]  = enc_r(OpSlt, 5'd6, 5'd5, 5'd0);
    dut.i_f.mem[7]  = enc_i(OpSlti, 5'd7, 5'd5, 16'hFFFE);
    dut.i_f.mem[8]  = enc_r(OpSub, 5'd8, 5'd0, 5'd3);
    dut.i_f.mem[9]  = enc_r(OpAnd, 5'd9, 5'd3, 5'd5);
    dut.i_f.mem[10] = enc_r(OpMul, 5'd10, 5'd5, 5'd5);
    sb.push_back(mk("wrap_muli", 0, 4, 32'h0000_0002));
    sb.push_back(mk("r0_zero", 0, 0, 32'd0));
    sb.push_back(mk("addi_neg", 0, 5, 32'hFFFF_FFFF));
    sb.push_back(mk("slt_signed", 0, 6, 32'd1));
    sb.push_back(mk("slti_false", 0, 7, 32'd0));
    sb.push_back(mk("sub_wrap", 0, 8, 32'h7FFF_FFFF));
    sb.push_back(mk("and", 0, 9, 32'h8000_0001));
    sb.push_back(mk("mul_neg", 0, 10, 32'd1));
    go();
    run(20);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.is_mem ? dut.max.data[e.idx] : dut.id.reg_b[e.idx];
      n_total++;
      if (act !== e.val) $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_hazard();
    prep();
    dut.max.data[1] = 32'd9;
    dut.i_f.mem[0]  = enc_i(OpLw, 5'd1, 5'd0, 16'd1);
    dut.i_f.mem[2]  = enc_r(OpAdd, 5'd3, 5'd1, 5'd1);
    dut.i_f.mem[3]  = enc_r(OpAdd, 5'd4, 5'd1, 5'd1);
    dut.i_f.mem[4]  = enc_r(OpAdd, 5'd5, 5'd1, 5'd1);
    sb.push_back(mk("haz_lw", 0, 1, 32'd9));
    sb.push_back(mk("haz_gap1", 0, 3, 32'd0));
`ifdef MIPS32_WB_BYPASS_EN
    sb.push_back(mk("haz_gap2", 0, 4, 32'd18));
`else
    sb.push_back(mk("haz_gap2", 0, 4, 32'd0));
`endif
    sb.push_back(mk("haz_gap3", 0, 5, 32'd18));
    go();
    run(12);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.is_mem ? dut.max.data[e.idx] : dut.id.reg_b[e.idx];
      n_total++;
      if (act !== e.val) $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    prep();
    dut.i_f.mem[0]  = enc_i(OpBeqz, 5'd1, 5'd0, 16'd5);
    dut.i_f.mem[1]  = enc_i(OpAddi, 5'd2, 5'd0, 16'd1);
    dut.i_f.mem[2]  = enc_i(OpAddi, 5'd3, 5'd0, 16'd1);
    dut.i_f.mem[3]  = enc_i(OpAddi, 5'd4, 5'd0, 16'd1);
    dut.i_f.mem[6]  = enc_i(OpBnez, 5'd1, 5'd0, 16'd3);
    dut.i_f.mem[7]  = enc_i(OpAddi, 5'd5, 5'd0, 16'd7);
    dut.i_f.mem[8]  = enc_i(OpAddi, 5'd6, 5'd0, 16'd8);
    dut.i_f.mem[9]  = enc_i(OpAddi, 5'd7, 5'd0, 16'd1);
    dut.i_f.mem[13] = enc_i(OpBnez, 5'd7, 5'd0, 16'd2);
    dut.i_f.mem[14] = enc_i(OpAddi, 5'd8, 5'd0, 16'd1);
    dut.i_f.mem[15] = enc_i(OpAddi, 5'd9, 5'd0, 16'd1);
    dut.i_f.mem[16] = enc_i(OpAddi, 5'd10, 5'd0, 16'd10);
    sb.push_back(mk("beqz_squash1", 0, 2, 32'd0));
    sb.push_back(mk("beqz_squash2", 0, 3, 32'd0));
    sb.push_back(mk("beqz_skip", 0, 4, 32'd0));
    sb.push_back(mk("bnez_fall1", 0, 5, 32'd7));
    sb.push_back(mk("bnez_fall2", 0, 6, 32'd8));
    sb.push_back(mk("bnez_src", 0, 7, 32'd1));
    sb.push_back(mk("bnez_squash1", 0, 8, 32'd0));
    sb.push_back(mk("bnez_squash2", 0, 9, 32'd0));
    sb.push_back(mk("bnez_target", 0, 10, 32'd10));
    go();
    run(25);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.is_mem ? dut.max.data[e.idx] : dut.id.reg_b[e.idx];
      n_total++;
      if (act !== e.val) $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_branch_over_halt();
    prep();
    dut.i_f.mem[0] = enc_i(OpBeqz, 5'd0, 5'd0, 16'd3);
    dut.i_f.mem[1] = Hlt;
    dut.i_f.mem[2] = enc_i(OpAddi, 5'd2, 5'd0, 16'd1);
    dut.i_f.mem[4] = enc_i(OpAddi, 5'd1, 5'd0, 16'd1);
    dut.i_f.mem[5] = Hlt;
    sb.push_back(mk("boh_target", 0, 1, 32'd1));
    sb.push_back(mk("boh_squash", 0, 2, 32'd0));
    go();
    run(3);
    n_total++;
    if (halt_x !== 1'b0) $display("FAIL boh_hlt_squashed: got %b expected 0", halt_x);
    else n_pass++;
    run(9);
    n_total++;
    if (halt_x !== 1'b1) $display("FAIL boh_halt: got %b expected 1", halt_x);
    else n_pass++;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.is_mem ? dut.max.data[e.idx] : dut.id.reg_b[e.idx];
      n_total++;
      if (act !== e.val) $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    prep();
    dut.i_f.mem[1] = enc_i(OpAddi, 5'd7, 5'd0, 16'd3);
    dut.i_f.mem[4] = enc_i(OpAddi, 5'd8, 5'd0, 16'd4);
    dut.i_f.mem[5] = Hlt;
    dut.i_f.mem[6] = enc_i(OpAddi, 5'd5, 5'd0, 16'd1);
    dut.i_f.mem[7] = enc_i(OpAddi, 5'd6, 5'd0, 16'd1);
    sb.push_back(mk("halt_older1", 0, 7, 32'd3));
    sb.push_back(mk("halt_older2", 0, 8, 32'd4));
    sb.push_back(mk("halt_young1", 0, 5, 32'd0));
    sb.push_back(mk("halt_young2", 0, 6, 32'd0));
    go();
    run(6);
    n_total++;
    if (halt_x !== 1'b0) $display("FAIL halt_early: got %b expected 0", halt_x);
    else n_pass++;
    run(1);
    n_total++;
    if (halt_x !== 1'b1) $display("FAIL halt_rise: got %b expected 1", halt_x);
    else n_pass++;
    run(10);
    n_total++;
    if (dut.pc_q !== 10'd6) $display("FAIL halt_pc: got %0d expected 6", dut.pc_q);
    else n_pass++;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.is_mem ? dut.max.data[e.idx] : dut.id.reg_b[e.idx];
      n_total++;
      if (act !== e.val) $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    prep();
    dut.i_f.mem[0] = enc_i(OpAddi, 5'd1, 5'd0, 16'h0055);
    dut.i_f.mem[5] = enc_i(OpSw, 5'd1, 5'd0, 16'd3);
    dut.i_f.mem[6] = Hlt;
    go();
    run(8);
    n_total++;
    if (halt_x !== 1'b1) $display("FAIL mid_halt_before: got %b expected 1", halt_x);
    else n_pass++;
    rst_x = 1'b1;
    run(1);
    n_total++;
    if (dut.max.data[3] !== 32'd0)
      $display("FAIL mid_sw_suppressed: got %h expected 0", dut.max.data[3]);
    else n_pass++;
    n_total++;
    if (halt_x !== 1'b0) $display("FAIL mid_halt_cleared: got %b expected 0", halt_x);
    else n_pass++;
    n_total++;
    if (dut.pc_q !== 10'd0) $display("FAIL mid_pc: got %0d expected 0", dut.pc_q);
    else n_pass++;
    rst_x = 1'b0;
    sb.push_back(mk("mid_restart_sw", 1, 3, 32'h55));
    run(12);
    n_total++;
    if (halt_x !== 1'b1) $display("FAIL mid_rehalt: got %b expected 1", halt_x);
    else n_pass++;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.is_mem ? dut.max.data[e.idx] : dut.id.reg_b[e.idx];
      n_total++;
      if (act !== e.val) $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      else n_pass++;
    end
  endtask

  initial begin
    rst_x = 1'b1;
    test_reset();
    test_basic();
    test_wrap_r0();
    test_hazard();
    test_branch();
    test_branch_over_halt();
    test_halt();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
